// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : Asynchronous 8-bit serial receiver (receive side of uart_tx).
//            Oversamples the serial line in the clk_48mhz domain, samples
//            each bit at its midpoint, and presents every good byte on
//            'data' together with a one-cycle 'data_strobe'.
// Options  : `define UART_RX_PARITY_EN to add a parity bit between the data
//            bits and the stop bit (even parity, or odd if PARITY_ODD=1).
//            Without it the frame is 8N1 and parity_error is tied low.
// Params   : CLKS_PER_BIT - clk_48mhz cycles per bit (>= 4)
//            PARITY_ODD   - 0 = even, 1 = odd (parity build only)
// Ports    : clk_48mhz     in   clock, rising edge
//            reset         in   synchronous, active-high
//            serial        in   asynchronous line, idles high
//            data          out  last good byte, held until the next one
//            data_strobe   out  one-cycle pulse, data valid same cycle
//            framing_error out  one-cycle pulse, stop bit sampled low
//            parity_error  out  one-cycle pulse, parity mismatch
//            busy          out  high from start edge until back in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       serial,
  output logic [7:0] data,
  output logic       data_strobe,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    PARITY    = 3'd5
`endif
  } state_t;

  state_t               r_state;
  logic [1:0]           r_sync;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2:0]           r_bit_idx;
  logic [7:0]           r_shift;
  logic                 w_rx;

  // r_sync[1] is the metastability-filtered copy of the line.
  assign w_rx = r_sync[1];

`ifdef UART_RX_PARITY_EN
  logic r_parity_fault;
  logic r_parity_error;
  logic w_parity_exp;

  // Expected parity bit: even parity makes the total count of ones even.
  assign w_parity_exp = (^r_shift) ^ PARITY_ODD;
  assign parity_error = r_parity_error;
`else
  logic w_unused_parity_odd;

  assign w_unused_parity_odd = PARITY_ODD;
  assign parity_error        = 1'b0;
`endif

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_sync         <= 2'b11;
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_bit_idx      <= '0;
      r_shift        <= '0;
      data           <= '0;
      data_strobe    <= 1'b0;
      framing_error  <= 1'b0;
      busy           <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_fault <= 1'b0;
      r_parity_error <= 1'b0;
`endif
    end else begin
      r_sync        <= {r_sync[0], serial};
      data_strobe   <= 1'b0;
      framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_error <= 1'b0;
`endif

      case (r_state)
        IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
          r_parity_fault <= 1'b0;
`endif
          if (!w_rx) begin
            r_state <= START;
            busy    <= 1'b1;
          end
        end

        // Re-check the line at mid start bit so short glitches are rejected.
        START: begin
          if (r_cnt == c_HALF_LAST) begin
            r_cnt <= '0;
            if (w_rx) begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end else begin
              r_state <= DATA;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        // Counter wraps each bit, so every sample lands on a bit midpoint.
        DATA: begin
          if (r_cnt == c_BIT_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

`ifdef UART_RX_PARITY_EN
        // The fault is only acted on once the stop bit is confirmed good.
        PARITY: begin
          if (r_cnt == c_BIT_LAST) begin
            r_cnt          <= '0;
            r_parity_fault <= (w_rx != w_parity_exp);
            r_state        <= STOP;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
`endif

        STOP: begin
          if (r_cnt == c_BIT_LAST) begin
            r_cnt <= '0;
            if (w_rx) begin
`ifdef UART_RX_PARITY_EN
              if (r_parity_fault) begin
                r_parity_error <= 1'b1;
              end else begin
                data        <= r_shift;
                data_strobe <= 1'b1;
              end
`else
              data        <= r_shift;
              data_strobe <= 1'b1;
`endif
              r_state <= IDLE;
              busy    <= 1'b0;
            end else begin
              framing_error <= 1'b1;
              r_state       <= WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end

        // A held-low line (break) reports once, then waits for idle.
        WAIT_IDLE: begin
          r_cnt <= '0;
          if (w_rx) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
